mips_muldiv_unit: RTL and testbench

// - Iterative multiply/divide unit with HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
// - Consumes the register-file read ports: operand A comes from R1 (rs) and operand B from R2 (rt).
// - Hi/Lo outputs feed the writeback mux for MFHI/MFLO.
// - Busy stalls the pipeline while an operation is in flight.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_muldiv_step.sv | 36 +++
 rtl/mips_muldiv_unit.sv | 133 +++++++++++++
 tb/tb_mips_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
// Covers the op encodings, the FSM state type and small op decode helpers.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX
    } md_state_t;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational multiply/divide iteration.
// In multiply mode it does a shift-add; in divide mode it does a restoring trial-subtract.
module mips_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] shifted;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted  = {acc[2*WIDTH-2:0], 1'b0};
        // The bit shifted out of the remainder joins the trial subtraction, so no bit is lost.
        diff     = {acc[2*WIDTH-1], shifted[2*WIDTH-1:WIDTH]} - {1'b0, operand};
        acc_next = shifted;
        q_bit    = 1'b0;
        if (mode) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], shifted[WIDTH-1:0]};
                q_bit    = 1'b1;
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// It works on magnitudes for WIDTH iterations, then applies the sign fixup in a final FIX cycle.
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWE,
    input  logic [WIDTH-1:0] HiDin,
    input  logic             LoWE,
    input  logic [WIDTH-1:0] LoDin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    md_state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_zero;

    logic               start_ok;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   hi_res, lo_res;

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .mode     (is_div),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_comb begin
        start_ok = (state == MD_IDLE) && Start;
        a_neg    = md_is_signed(Op) & A[WIDTH-1];
        b_neg    = md_is_signed(Op) & B[WIDTH-1];
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= MD_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (Start) state_next = MD_CALC;
            MD_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_next = MD_FIX;
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != MD_IDLE);
    end

    // Multiply keeps the multiplier in the low half of acc; divide keeps the dividend there.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else if (start_ok) begin
            cnt      <= '0;
            is_div   <= md_is_div(Op);
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            div_zero <= (B == '0);
            acc      <= md_is_div(Op) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd     <= md_is_div(Op) ? b_mag : a_mag;
        end else if (state == MD_CALC) begin
            cnt <= cnt + 1'b1;
            acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
        end
    end

    always_comb begin
        prod_res = neg_lo ? -acc : acc;
        quot     = acc[WIDTH-1:0];
        rem      = acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            hi_res = neg_hi ? -rem : rem;
            lo_res = div_zero ? '1 : (neg_lo ? -quot : quot);
        end else begin
            hi_res = prod_res[2*WIDTH-1:WIDTH];
            lo_res = prod_res[WIDTH-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Hi   <= '0;
            Lo   <= '0;
            Done <= 1'b0;
        end else begin
            Done <= (state == MD_FIX);
            if (state == MD_FIX) begin
                Hi <= hi_res;
                Lo <= lo_res;
            end else if (state == MD_IDLE) begin
                if (HiWE) Hi <= HiDin;
                if (LoWE) Lo <= LoDin;
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit.
// Results are compared against a reference built from 64-bit integer arithmetic.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_we, lo_we;
    logic [31:0] hi_din, lo_din;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests_run = 0;
    int failed    = 0;

    mips_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .Start (start),
        .Op    (op),
        .A     (a),
        .B     (b),
        .HiWE  (hi_we),
        .HiDin (hi_din),
        .LoWE  (lo_we),
        .LoDin (lo_din),
        .Busy  (busy),
        .Done  (done),
        .Hi    (hi),
        .Lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void ref_model(input logic [1:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                                      output logic [31:0] rhi, output logic [31:0] rlo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(ra);
        sb = $signed(rb);
        case (rop)
            MD_MULT: begin
                p = sa * sb;
                rhi = p[63:32];
                rlo = p[31:0];
            end
            MD_MULTU: begin
                p = {32'b0, ra} * {32'b0, rb};
                rhi = p[63:32];
                rlo = p[31:0];
            end
            MD_DIV: begin
                if (rb == 0) begin
                    rhi = ra;
                    rlo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    rhi = r[31:0];
                    rlo = q[31:0];
                end
            end
            default: begin
                if (rb == 0) begin
                    rhi = ra;
                    rlo = 32'hFFFF_FFFF;
                end else begin
                    rhi = ra % rb;
                    rlo = ra / rb;
                end
            end
        endcase
    endfunction

    // Launches one op and waits for Done; lat is the negedge count from launch, or -1 on timeout.
    task automatic do_op(input logic [1:0] dop, input logic [31:0] da, input logic [31:0] db, output int lat);
        int n;
        @(negedge clk);
        start = 1'b1; op = dop; a = da; b = db;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = done ? n : -1;
    endtask

    task automatic test_reset();
        start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; hi_din = 0; lo_din = 0;
        rst_n = 1'b0;
        #12;
        tests_run++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            failed++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            failed++;
            $display("FAIL reset_release_idle: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [4] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
        logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100};
        logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd0};
        logic [31:0] ehi [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0064};
        logic [31:0] elo [4] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], lat);
            tests_run++;
            if (lat !== 34) begin
                failed++;
                $display("FAIL directed%0d_latency: got %0d cycles, required 34", i, lat);
            end
            tests_run++;
            if ({hi, lo} !== {ehi[i], elo[i]}) begin
                failed++;
                $display("FAIL directed%0d_result: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, ehi[i], elo[i]);
            end
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL directed%0d_done_pulse: done=%b busy=%b one cycle later, required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  rop;
        logic [31:0] ra, rb, ehi, elo;
        int lat, sel;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'd1;
            else if (sel == 3) rb = ($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 255)) : 32'($urandom_range(1, 255));
            else if (sel == 4) ra = -32'($urandom_range(0, 1000));
            ref_model(rop, ra, rb, ehi, elo);
            do_op(rop, ra, rb, lat);
            tests_run++;
            if (lat !== 34 || {hi, lo} !== {ehi, elo}) begin
                failed++;
                $display("FAIL random%0d op=%0d a=%h b=%h: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=34",
                         i, rop, ra, rb, hi, lo, lat, ehi, elo);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        @(negedge clk);
        hi_we = 1; hi_din = 32'h1111_2222; lo_we = 1; lo_din = 32'h3333_4444;
        @(negedge clk);
        hi_we = 0; lo_we = 0;
        tests_run++;
        if ({hi, lo} !== {32'h1111_2222, 32'h3333_4444}) begin
            failed++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required 11112222 33334444", hi, lo);
        end
        hi_we = 1; hi_din = 32'h5555_6666;
        @(negedge clk);
        hi_we = 0;
        tests_run++;
        if ({hi, lo} !== {32'h5555_6666, 32'h3333_4444}) begin
            failed++;
            $display("FAIL mthi_only: hi=%h lo=%h, required 55556666 33334444", hi, lo);
        end
        start = 1; op = MD_MULTU; a = 32'd3; b = 32'd5; hi_we = 1; hi_din = 32'h0000_AAAA;
        @(negedge clk);
        start = 0; hi_we = 0;
        tests_run++;
        if (hi !== 32'h0000_AAAA || busy !== 1'b1) begin
            failed++;
            $display("FAIL mthi_with_start: hi=%h busy=%b, required 0000aaaa 1", hi, busy);
        end
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (lat !== 34 || {hi, lo} !== {32'd0, 32'd15}) begin
            failed++;
            $display("FAIL mthi_with_start_overwrite: hi=%h lo=%h lat=%0d, required 0 0000000f 34", hi, lo, lat);
        end
    endtask

    task automatic test_busy_reject();
        logic [31:0] hi_before, ehi, elo;
        int n;
        bit early_drop;
        ref_model(MD_DIVU, 32'd1000003, 32'd7, ehi, elo);
        @(negedge clk);
        hi_before = hi;
        start = 1; op = MD_DIVU; a = 32'd1000003; b = 32'd7;
        @(negedge clk);
        start = 0;
        n = 1;
        early_drop = 0;
        while (!done && n < 100) begin
            if (!busy) early_drop = 1;
            if (n == 10) begin
                start = 1; op = MD_MULT; a = 32'h0BAD_0BAD; b = 32'h0000_0003;
                hi_we = 1; hi_din = 32'h0000_1234;
            end else begin
                start = 0; hi_we = 0;
            end
            if (n == 12) begin
                tests_run++;
                if (hi !== hi_before) begin
                    failed++;
                    $display("FAIL busy_mthi_ignored: hi=%h, required %h", hi, hi_before);
                end
            end
            @(negedge clk);
            n++;
        end
        start = 0; hi_we = 0;
        tests_run++;
        if (early_drop !== 1'b0) begin
            failed++;
            $display("FAIL busy_held: busy dropped before done");
        end
        tests_run++;
        if (n !== 34 || {hi, lo} !== {ehi, elo}) begin
            failed++;
            $display("FAIL busy_start_ignored: hi=%h lo=%h lat=%0d, required hi=%h lo=%h lat=34", hi, lo, n, ehi, elo);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL busy_no_queued_op: busy=%b after done, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        hi_we = 1; hi_din = 32'hDEAD_0000;
        @(negedge clk);
        hi_we = 0;
        start = 1; op = MD_MULT; a = 32'h1234_5678; b = 32'h8765_4321;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            failed++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lo_we = 1; lo_din = 32'h0000_CAFE;
        @(negedge clk);
        lo_we = 0;
        tests_run++;
        if ({busy, hi, lo} !== {1'b0, 32'd0, 32'h0000_CAFE}) begin
            failed++;
            $display("FAIL mtlo_after_reset: busy=%b hi=%h lo=%h, required 0 0 0000cafe", busy, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mthi_mtlo();
        test_busy_reject();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
